// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for a single shared ALU: IDLE/BUSY/RESP handshake with registered operands and result.
// Define ALU_ARB_ROUND_ROBIN_EN to rotate contention priority; otherwise requester 1 always wins.
module alu_share_arbiter #(
  parameter int BITWIDTH = 32,
  parameter int OPWIDTH  = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                req_1_valid,
  input  logic [BITWIDTH-1:0] req_1_a,
  input  logic [BITWIDTH-1:0] req_1_b,
  input  logic [OPWIDTH-1:0]  req_1_op,
  output logic                req_1_ready,
  input  logic                req_2_valid,
  input  logic [BITWIDTH-1:0] req_2_a,
  input  logic [BITWIDTH-1:0] req_2_b,
  input  logic [OPWIDTH-1:0]  req_2_op,
  output logic                req_2_ready,
  output logic                grant,
  output logic [BITWIDTH-1:0] alu_a,
  output logic [BITWIDTH-1:0] alu_b,
  output logic [OPWIDTH-1:0]  alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [BITWIDTH-1:0] alu_result,
  output logic                rsp_1_valid,
  output logic                rsp_2_valid,
  output logic [BITWIDTH-1:0] rsp_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t              r_state, w_next;
  logic                w_ptr, w_sel, w_acc;
  logic                r_grant, r_start;
  logic [BITWIDTH-1:0] r_alu_a, r_alu_b, r_rsp_data;
  logic [OPWIDTH-1:0]  r_alu_op;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic r_ptr;
  // Priority flips once per completed operation, i.e. on every RESP->IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                r_ptr <= 1'b0;
    else if (r_state == RESP)  r_ptr <= ~r_ptr;
  end
  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  // Lone requester wins outright; contention or no request falls back to the pointer.
  always_comb begin
    w_sel = w_ptr;
    if (req_1_valid && !req_2_valid)      w_sel = 1'b0;
    else if (!req_1_valid && req_2_valid) w_sel = 1'b1;
  end

  assign w_acc = (r_state == IDLE) && (w_sel ? req_2_valid : req_1_valid);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc)    w_next = BUSY;
      BUSY:    if (alu_done) w_next = RESP;
      RESP:                  w_next = IDLE;
      default:               w_next = IDLE;
    endcase
  end

  always_comb begin
    req_1_ready = 1'b0;
    req_2_ready = 1'b0;
    rsp_1_valid = 1'b0;
    rsp_2_valid = 1'b0;
    grant       = r_grant;
    case (r_state)
      IDLE: begin
        grant       = w_sel;
        req_1_ready = req_1_valid && !w_sel;
        req_2_ready = req_2_valid &&  w_sel;
      end
      RESP: begin
        rsp_1_valid = !r_grant;
        rsp_2_valid =  r_grant;
      end
      default: ;
    endcase
  end

  // Operands and owner are only written on acceptance, so they hold for the whole BUSY wait.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_grant    <= 1'b0;
      r_start    <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_rsp_data <= '0;
    end else begin
      r_start <= w_acc;
      if (w_acc) begin
        r_grant  <= w_sel;
        r_alu_a  <= w_sel ? req_2_a  : req_1_a;
        r_alu_b  <= w_sel ? req_2_b  : req_1_b;
        r_alu_op <= w_sel ? req_2_op : req_1_op;
      end
      if (r_state == BUSY && alu_done) r_rsp_data <= alu_result;
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign alu_start = r_start;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; the ALU side is driven by hand.
// Contention expectations follow ALU_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_alu_share_arbiter;
  localparam int BW = 32;
  localparam int OW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          req_1_valid = 0, req_2_valid = 0;
  logic [BW-1:0] req_1_a = '0, req_1_b = '0, req_2_a = '0, req_2_b = '0;
  logic [OW-1:0] req_1_op = '0, req_2_op = '0;
  logic          req_1_ready, req_2_ready, grant, alu_start;
  logic [BW-1:0] alu_a, alu_b, rsp_data;
  logic [OW-1:0] alu_op;
  logic          alu_done = 0;
  logic [BW-1:0] alu_result = '0;
  logic          rsp_1_valid, rsp_2_valid;

  int n_cmp = 0;
  int n_err = 0;

  alu_share_arbiter #(.BITWIDTH(BW), .OPWIDTH(OW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_1_valid(req_1_valid), .req_1_a(req_1_a), .req_1_b(req_1_b), .req_1_op(req_1_op),
    .req_1_ready(req_1_ready),
    .req_2_valid(req_2_valid), .req_2_a(req_2_a), .req_2_b(req_2_b), .req_2_op(req_2_op),
    .req_2_ready(req_2_ready),
    .grant(grant), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_1_valid(rsp_1_valid), .rsp_2_valid(rsp_2_valid), .rsp_data(rsp_data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    @(posedge CLK);
    #1 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    #1;
  endtask

  initial begin
    logic [BW-1:0] exp_a;
    logic          exp_g;

    // Reset values while RST_N is held low
    tick; tick;
    chk("rst_grant", grant, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_rsp", {rsp_2_valid, rsp_1_valid}, 0);
    chk("rst_data", rsp_data, 0);
    RST_N = 1'b1;
    tick;

    // Basic op from requester 1: 5+7, done at T+1
    req_1_valid = 1; req_1_a = 5; req_1_b = 7; req_1_op = 0;
    #1;
    chk("b_rdy1", req_1_ready, 1);
    chk("b_rdy2", req_2_ready, 0);
    chk("b_grant", grant, 0);
    tick;                                   // T+1
    req_1_valid = 0; alu_done = 1; alu_result = 12;
    chk("b_start", alu_start, 1);
    chk("b_alu_a", alu_a, 5);
    chk("b_alu_b", alu_b, 7);
    chk("b_busy_rdy", req_1_ready, 0);
    tick;                                   // T+2
    alu_done = 0;
    chk("b_rsp1", rsp_1_valid, 1);
    chk("b_rsp2", rsp_2_valid, 0);
    chk("b_data", rsp_data, 12);
    chk("b_start_off", alu_start, 0);
    tick;
    chk("b_rsp1_off", rsp_1_valid, 0);
    chk("b_data_hold", rsp_data, 12);

    // Contention: both held valid, done held high
    do_reset;
    req_1_a = 100; req_1_b = 1; req_1_op = 1;
    req_2_a = 200; req_2_b = 2; req_2_op = 2;
    req_1_valid = 1; req_2_valid = 1;
    alu_done = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_g = i[0];
`else
      exp_g = 1'b0;
`endif
      exp_a = exp_g ? 200 : 100;
      alu_result = 1000 + i;
      #1;
      chk($sformatf("c%0d_grant", i), grant, exp_g);
      chk($sformatf("c%0d_rdy", i), {req_2_ready, req_1_ready}, exp_g ? 2'b10 : 2'b01);
      tick;
      chk($sformatf("c%0d_alu_a", i), alu_a, exp_a);
      tick;
      chk($sformatf("c%0d_rsp", i), {rsp_2_valid, rsp_1_valid}, exp_g ? 2'b10 : 2'b01);
      chk($sformatf("c%0d_data", i), rsp_data, 1000 + i);
      tick;
    end
    req_1_valid = 0; req_2_valid = 0; alu_done = 0;

    // Requester 2 alone, done delayed 5 cycles after start
    do_reset;
    req_2_valid = 1; req_2_a = 3; req_2_b = 9; req_2_op = 5;
    #1;
    chk("d_grant_idle", grant, 1);
    chk("d_rdy2", req_2_ready, 1);
    tick;                                   // T+1
    req_2_valid = 0; req_2_a = 77; req_2_b = 88; req_2_op = 15;
    chk("d_start", alu_start, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("d%0d_stable", i), {alu_a, alu_b}, {32'd3, 32'd9});
      chk($sformatf("d%0d_op_grant", i), {alu_op, grant}, {4'd5, 1'b1});
      chk($sformatf("d%0d_norsp", i), {rsp_2_valid, rsp_1_valid, alu_start}, 0);
    end
    alu_done = 1; alu_result = 32'hCAFE;    // T+6
    tick;
    alu_done = 0;
    chk("d_rsp2", {rsp_2_valid, rsp_1_valid}, 2'b10);
    chk("d_data", rsp_data, 32'hCAFE);

    // Valid withdrawn before the edge is not accepted
    tick;
    req_2_valid = 1;
    #1;
    chk("w_grant", grant, 1);
    req_2_valid = 0;
    tick;
    chk("w_nostart", alu_start, 0);

    // Reset in the cycle after alu_start
    req_1_valid = 1; req_1_a = 11; req_1_b = 22; req_1_op = 3;
    tick;
    req_1_valid = 0;
    chk("r_start", alu_start, 1);
    RST_N = 1'b0;
    #1;
    chk("r_start0", alu_start, 0);
    chk("r_ab0", {alu_a, alu_b}, 0);
    chk("r_op_grant0", {alu_op, grant}, 0);
    chk("r_data0", rsp_data, 0);
    tick;
    RST_N = 1'b1;
    alu_done = 1; alu_result = 32'h55;
    tick; tick;
    chk("r_norsp", {rsp_2_valid, rsp_1_valid}, 0);
    chk("r_data_ign", rsp_data, 0);

    // alu_done in IDLE with no requests is ignored
    alu_done = 1; alu_result = 32'h99;
    tick;
    alu_done = 0;
    tick;
    chk("i_norsp", {rsp_2_valid, rsp_1_valid, alu_start}, 0);
    chk("i_data", rsp_data, 0);
    req_1_valid = 1;
    #1;
    chk("i_still_idle", req_1_ready, 1);
    req_1_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
